// File: rtl/calc_pkg.sv
// Shared constants for the calculator keypad: key indices, bus widths and a
// small helper used when picking one key out of several.
package calc_pkg;

    localparam int KEY_W      = 6;
    localparam int KEY_CODE_W = 3;
    localparam int CNT_W      = 24;

    localparam int KEY_NUM0  = 0;
    localparam int KEY_NUM1  = 1;
    localparam int KEY_PLUS  = 2;
    localparam int KEY_MINUS = 3;
    localparam int KEY_EQUAL = 4;
    localparam int KEY_CLEAR = 5;

    // Scanning from the top down leaves the lowest set index as the result.
    function automatic logic [KEY_CODE_W-1:0] lowest_index(input logic [KEY_W-1:0] v);
        lowest_index = '0;
        for (int i = KEY_W - 1; i >= 0; i--) begin
            if (v[i]) begin
                lowest_index = KEY_CODE_W'(i);
            end
        end
    endfunction

endpackage

// File: rtl/key_debounce_cell.sv
// One key: two-flop synchronizer, stability counter and debounced level.
// rise flags the edge on which the level is about to go from 0 to 1.
module key_debounce_cell
    import calc_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 2000000
) (
    input  logic clk,
    input  logic reset,
    input  logic key_raw,
    output logic level,
    output logic rise
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] count;
    logic             differ;
    logic             accept;

    assign differ = (sync2 != level);
    assign accept = differ && (count == CNT_LAST);

    // Left unregistered so the parent can capture the press on the same edge
    // that level changes; it depends only on flops, never on key_raw directly.
    assign rise = accept && sync2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            count <= '0;
            level <= 1'b0;
        end else begin
            sync1 <= key_raw;
            sync2 <= sync1;
            if (!differ) begin
                count <= '0;
            end else if (accept) begin
                count <= '0;
                level <= sync2;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/key_conditioner.sv
// Debounces the six calculator buttons and turns presses into single-cycle
// key events, ignoring a press while another key is already held down.
module key_conditioner
    import calc_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 2000000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [KEY_W-1:0]      keys_raw,
    output logic [KEY_W-1:0]      key_level,
    output logic [KEY_W-1:0]      key_pulse,
    output logic                  key_valid,
    output logic [KEY_CODE_W-1:0] key_code,
    output logic                  key_multi
);

    logic [KEY_W-1:0] level_now;
    logic [KEY_W-1:0] rise;
    logic [KEY_W-1:0] eligible;
    logic [KEY_W-1:0] chosen;
    logic             several;

    for (genvar g = 0; g < KEY_W; g++) begin : g_cell
        key_debounce_cell #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_cell (
            .clk    (clk),
            .reset  (reset),
            .key_raw(keys_raw[g]),
            .level  (level_now[g]),
            .rise   (rise[g])
        );
    end

    // level_now is already a flop inside each cell, so this stays registered.
    assign key_level = level_now;

    // A press only counts if no other key was down before this edge.
    always_comb begin
        logic [KEY_W-1:0] others;
        eligible = '0;
        others   = '0;
        for (int i = 0; i < KEY_W; i++) begin
            others      = level_now;
            others[i]   = 1'b0;
            eligible[i] = rise[i] && (others == '0);
        end
    end

    assign chosen  = eligible & (~eligible + 1'b1);
    assign several = |(eligible & (eligible - 1'b1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            key_pulse <= '0;
            key_valid <= 1'b0;
            key_multi <= 1'b0;
            key_code  <= '0;
        end else begin
            key_pulse <= chosen;
            key_valid <= |eligible;
            key_multi <= several;
            if (|eligible) begin
                key_code <= lowest_index(eligible);
            end
        end
    end

endmodule

// File: tb/tb_key_conditioner.sv
// Checks key_conditioner against a sample-history model of the debouncer,
// using directed scenarios followed by random button activity.
module tb_key_conditioner;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] keys_raw = '0;
    logic [5:0] key_level;
    logic [5:0] key_pulse;
    logic       key_valid;
    logic [2:0] key_code;
    logic       key_multi;

    int checks = 0;
    int failures = 0;
    bit checking = 1'b0;
    int valid_count = 0;

    logic [5:0] hist [0:D+1];
    logic [5:0] m_level = '0;
    logic [5:0] m_pulse = '0;
    logic       m_valid = 1'b0;
    logic       m_multi = 1'b0;
    logic [2:0] m_code = '0;
    logic [5:0] next_level;
    logic [5:0] press;
    logic [5:0] others;
    logic       all_differ;
    int         n_press;

    key_conditioner #(
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .keys_raw (keys_raw),
        .key_level(key_level),
        .key_pulse(key_pulse),
        .key_valid(key_valid),
        .key_code (key_code),
        .key_multi(key_multi)
    );

    always #5 clk = ~clk;

    // hist[0] is the sample taken at this edge; the level flips once the D
    // samples two or more edges old all disagree with it.
    always @(posedge clk) begin
        if (reset) begin
            for (int j = 0; j <= D + 1; j++) hist[j] = '0;
            m_level = '0;
            m_pulse = '0;
            m_valid = 1'b0;
            m_multi = 1'b0;
            m_code  = '0;
        end else begin
            for (int j = D + 1; j > 0; j--) hist[j] = hist[j-1];
            hist[0] = keys_raw;
            next_level = m_level;
            press = '0;
            for (int i = 0; i < 6; i++) begin
                all_differ = 1'b1;
                for (int j = 2; j <= D + 1; j++) begin
                    if (hist[j][i] == m_level[i]) all_differ = 1'b0;
                end
                if (all_differ) begin
                    next_level[i] = ~m_level[i];
                    others = m_level;
                    others[i] = 1'b0;
                    if (!m_level[i] && others == '0) press[i] = 1'b1;
                end
            end
            n_press = 0;
            m_pulse = '0;
            for (int i = 0; i < 6; i++) begin
                if (press[i]) begin
                    if (n_press == 0) begin
                        m_pulse[i] = 1'b1;
                        m_code = 3'(i);
                    end
                    n_press++;
                end
            end
            m_valid = (n_press > 0);
            m_multi = (n_press > 1);
            m_level = next_level;
        end
    end

    task automatic check_output(input string name, input logic [7:0] actual,
                                input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        if (checking) begin
            check_output("model_level", 8'(key_level), 8'(m_level));
            check_output("model_pulse", 8'(key_pulse), 8'(m_pulse));
            check_output("model_valid", 8'(key_valid), 8'(m_valid));
            check_output("model_code",  8'(key_code),  8'(m_code));
            check_output("model_multi", 8'(key_multi), 8'(m_multi));
            check_output("pulse_onehot0", 8'($onehot0(key_pulse)), 8'd1);
        end
    end

    task automatic apply_stimulus(input logic rst, input logic [5:0] keys);
        #1;
        reset = rst;
        keys_raw = keys;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            if (key_valid) valid_count++;
        end
    endtask

    task automatic restart(input logic [5:0] keys);
        apply_stimulus(1'b1, '0);
        tick(2);
        valid_count = 0;
        apply_stimulus(1'b0, keys);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        checking = 1'b1;
        check_output("reset_level", 8'(key_level), 8'h00);
        check_output("reset_pulse", 8'(key_pulse), 8'h00);
        check_output("reset_code",  8'(key_code),  8'h00);

        // single press of plus
        apply_stimulus(1'b0, 6'b000100);
        tick(5);
        check_output("press_early_pulse", 8'(key_pulse), 8'h00);
        check_output("press_early_level", 8'(key_level), 8'h00);
        tick(1);
        check_output("press_pulse", 8'(key_pulse), 8'h04);
        check_output("press_valid", 8'(key_valid), 8'h01);
        check_output("press_code",  8'(key_code),  8'h02);
        check_output("press_level", 8'(key_level), 8'h04);
        tick(1);
        check_output("press_after_pulse", 8'(key_pulse), 8'h00);
        check_output("press_after_level", 8'(key_level), 8'h04);

        // three-cycle glitch on num_0
        restart(6'b000001);
        tick(3);
        apply_stimulus(1'b0, 6'b000000);
        tick(10);
        check_output("glitch_level", 8'(key_level), 8'h00);
        check_output("glitch_events", 8'(valid_count), 8'h00);

        // num_1 and equal together
        restart(6'b010010);
        tick(6);
        check_output("simul_pulse", 8'(key_pulse), 8'h02);
        check_output("simul_code",  8'(key_code),  8'h01);
        check_output("simul_multi", 8'(key_multi), 8'h01);
        check_output("simul_level", 8'(key_level), 8'h12);
        tick(1);
        check_output("simul_after_multi", 8'(key_multi), 8'h00);
        tick(10);
        check_output("simul_events", 8'(valid_count), 8'h01);

        // interlock: minus held, num_0 pressed
        restart(6'b001000);
        tick(6);
        check_output("lock_first_code", 8'(key_code), 8'h03);
        apply_stimulus(1'b0, 6'b001001);
        valid_count = 0;
        tick(10);
        check_output("lock_events", 8'(valid_count), 8'h00);
        check_output("lock_level",  8'(key_level),  8'h09);
        check_output("lock_code",   8'(key_code),   8'h03);
        apply_stimulus(1'b0, 6'b000000);
        tick(10);
        check_output("lock_release_level", 8'(key_level), 8'h00);
        apply_stimulus(1'b0, 6'b000001);
        tick(6);
        check_output("lock_again_pulse", 8'(key_pulse), 8'h01);
        check_output("lock_again_code",  8'(key_code),  8'h00);
        check_output("lock_again_valid", 8'(key_valid), 8'h01);

        // reset mid-count while clear is held
        restart(6'b100000);
        tick(4);
        apply_stimulus(1'b1, 6'b100000);
        tick(3);
        check_output("rst_mid_events", 8'(valid_count), 8'h00);
        check_output("rst_mid_code",   8'(key_code),    8'h00);
        apply_stimulus(1'b0, 6'b100000);
        tick(5);
        check_output("rst_early_pulse", 8'(key_pulse), 8'h00);
        tick(1);
        check_output("rst_pulse", 8'(key_pulse), 8'h20);
        check_output("rst_code",  8'(key_code),  8'h05);

        // long hold on equal
        restart(6'b010000);
        tick(100);
        apply_stimulus(1'b0, 6'b000000);
        tick(5);
        check_output("hold_level_before", 8'(key_level), 8'h10);
        tick(1);
        check_output("hold_level_after", 8'(key_level), 8'h00);
        check_output("hold_events", 8'(valid_count), 8'h01);

        // random button activity with occasional resets
        restart(6'b000000);
        for (int c = 0; c < 3000; c++) begin
            int r;
            @(negedge clk);
            #1;
            r = $urandom_range(0, 199);
            if (reset) reset = 1'b0;
            else if (r == 0) reset = 1'b1;
            if (r < 25) keys_raw[$urandom_range(0, 5)] ^= 1'b1;
            else if (r == 100) keys_raw = 6'($urandom);
            else if (r == 101) keys_raw = '0;
        end

        tick(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
